// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing/overrun pulses.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             frame_ok_c, frame_bad_c;

  // Two-flop synchroniser; line idles high so both flops reset to 1
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, bit-time counter, bit index and shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // Next-state logic; frame_ok_c/frame_bad_c flag the stop-bit sample cycle
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shift_nxt   = shift;
    frame_ok_c  = 1'b0;
    frame_bad_c = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          // a start bit that is high again by mid-bit was only a glitch
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            frame_ok_c = 1'b1;
            state_nxt  = IDLE;
          end else begin
            frame_bad_c = 1'b1;
            state_nxt   = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        // hold off until the line returns high so a break is not a new start
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Holding register and one-cycle error pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= frame_bad_c;
      overrun     <= 1'b0;
      if (frame_ok_c) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          data_valid <= 1'b1;
        end else begin
          // holding register still occupied: keep old byte, drop the new one
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_deserializer: directed table, corner
// sequences and randomized frames against a byte-queue reference model.
module tb_uart_rx_deserializer;

  localparam int unsigned CPB     = 104;
  localparam int unsigned HALF    = CPB / 2;
  localparam int unsigned LAT_NOM = 2 + HALF + 9 * CPB + 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;

  // monitor state
  byte unsigned got_q[$];
  int          rise_cnt  = 0;
  int          ferr_cnt  = 0;
  int          ovr_cnt   = 0;
  int          both_cnt  = 0;
  int          stab_viol = 0;
  int          run       = 0;
  int          last_run  = 0;
  int unsigned last_rise = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_hold;
    int         gap;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Observe outputs mid-cycle: transfers, pulses, valid runs, stability
  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid && data_ready) got_q.push_back(data_out);
      if (frame_error) ferr_cnt <= ferr_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (frame_error && overrun) both_cnt <= both_cnt + 1;
      if (data_valid && !prev_valid) begin
        rise_cnt  <= rise_cnt + 1;
        last_rise <= cyc;
      end
      run <= data_valid ? run + 1 : 0;
      if (!data_valid && prev_valid) last_run <= run;
      if (prev_valid && !prev_ready && data_valid && (data_out !== prev_data))
        stab_viol <= stab_viol + 1;
    end
    prev_valid <= data_valid;
    prev_ready <= data_ready;
    prev_data  <= data_out;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] exp);
    logic [7:0] g;
    g = 8'hxx;
    if (got_q.size() != 0) g = got_q.pop_front();
    check(name, {24'd0, g}, {24'd0, exp});
  endtask

  task automatic check_latency(input string name);
    int lat;
    lat = int'(last_rise) - int'(fall_cyc);
    check(name, (lat >= int'(LAT_NOM) - 2 && lat <= int'(LAT_NOM) + 2) ? 1 : 0, 1);
    if (lat < int'(LAT_NOM) - 2 || lat > int'(LAT_NOM) + 2)
      $display("  latency was %0d cycles, nominal %0d", lat, LAT_NOM);
  endtask

  initial begin
    int r0, f0, o0;
    byte unsigned exp_q[$];
    int ferr_exp;

    vecs[0] = '{8'h00, 1'b1, 0,   0,  1, 0};
    vecs[1] = '{8'hFF, 1'b1, 0,   5,  1, 0};
    vecs[2] = '{8'h80, 1'b1, 0,   0,  1, 0};
    vecs[3] = '{8'h01, 1'b1, 0,   12, 1, 0};
    vecs[4] = '{8'hC3, 1'b0, 200, 10, 0, 1};
    vecs[5] = '{8'h5A, 1'b1, 0,   0,  1, 0};
    vecs[6] = '{8'h7E, 1'b0, 0,   20, 0, 1};
    vecs[7] = '{8'h96, 1'b1, 0,   3,  1, 0};

    reset      = 1'b1;
    uart_rx    = 1'b1;
    data_ready = 1'b1;
    tick(3);
    check("reset data_out", {24'd0, data_out}, 32'h00);
    check("reset data_valid", {31'd0, data_valid}, 0);
    check("reset frame_error", {31'd0, frame_error}, 0);
    check("reset overrun", {31'd0, overrun}, 0);
    reset = 1'b0;
    tick(10);

    // 0x55 with consumer ready: one-cycle valid, nominal latency
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h55, 1'b1);
    tick(10);
    check("s1 rises", rise_cnt - r0, 1);
    check("s1 valid run", last_run, 1);
    expect_byte("s1 data", 8'h55);
    check_latency("s1 latency");
    check("s1 ferr", ferr_cnt - f0, 0);
    check("s1 ovr", ovr_cnt - o0, 0);

    // 0x4B held while consumer stalls, then drained by a one-cycle ready
    data_ready = 1'b0;
    send_frame(8'h4B, 1'b1);
    tick(50);
    check("s2 valid held", {31'd0, data_valid}, 1);
    check("s2 data held", {24'd0, data_out}, 32'h4B);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    check("s2 valid cleared", {31'd0, data_valid}, 0);
    expect_byte("s2 drained", 8'h4B);

    // overrun: second byte arrives while first is still held
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h55, 1'b1);
    tick(4 * CPB);
    send_frame(8'h4B, 1'b1);
    tick(10);
    check("s3 ovr pulses", ovr_cnt - o0, 1);
    check("s3 valid", {31'd0, data_valid}, 1);
    check("s3 data kept", {24'd0, data_out}, 32'h55);
    check("s3 rises", rise_cnt - r0, 1);
    check("s3 ferr", ferr_cnt - f0, 0);
    data_ready = 1'b1;
    tick(3);
    check("s3 drained q", got_q.size(), 1);
    expect_byte("s3 first byte", 8'h55);

    // short low glitch is rejected, next frame received
    r0 = rise_cnt; f0 = ferr_cnt;
    uart_rx = 1'b0;
    tick(20);
    uart_rx = 1'b1;
    tick(200);
    check("s4 glitch rises", rise_cnt - r0, 0);
    check("s4 glitch ferr", ferr_cnt - f0, 0);
    send_frame(8'hA3, 1'b1);
    tick(10);
    check("s4 rises", rise_cnt - r0, 1);
    expect_byte("s4 data", 8'hA3);

    // bad stop, long break, then a clean frame
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b0);
    tick(300);
    uart_rx = 1'b1;
    tick(50);
    check("s5 ferr after break", ferr_cnt - f0, 1);
    check("s5 no byte", rise_cnt - r0, 0);
    send_frame(8'h3C, 1'b1);
    tick(10);
    check("s5 ferr total", ferr_cnt - f0, 1);
    check("s5 rises", rise_cnt - r0, 1);
    expect_byte("s5 data", 8'h3C);
    check("s5 ovr", ovr_cnt - o0, 0);

    // reset during data bit 3 of 0xFF, then a clean 0x81
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(3 * CPB + HALF);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("s6 rst data_out", {24'd0, data_out}, 32'h00);
    check("s6 rst valid", {31'd0, data_valid}, 0);
    check("s6 rst ferr", {31'd0, frame_error}, 0);
    check("s6 rst ovr", {31'd0, overrun}, 0);
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    tick(CPB - HALF - 1 + 5 * CPB);
    check("s6 no partial", rise_cnt - r0, 0);
    send_frame(8'h81, 1'b1);
    tick(10);
    check("s6 rises", rise_cnt - r0, 1);
    check("s6 ferr", ferr_cnt - f0, 0);
    check("s6 ovr", ovr_cnt - o0, 0);
    expect_byte("s6 data", 8'h81);

    // table-driven frames, consumer always ready
    for (int v = 0; v < 8; v++) begin
      r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      tick(vecs[v].low_hold);
      uart_rx = 1'b1;
      tick(vecs[v].gap);
      check($sformatf("t%0d rises", v), rise_cnt - r0, vecs[v].exp_bytes);
      check($sformatf("t%0d ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("t%0d ovr", v), ovr_cnt - o0, 0);
      if (vecs[v].exp_bytes != 0) begin
        expect_byte($sformatf("t%0d data", v), vecs[v].data);
        check_latency($sformatf("t%0d latency", v));
      end
    end
    tick(10);
    check("table queue empty", got_q.size(), 0);

    // randomized frames against a byte-queue reference
    f0 = ferr_cnt; o0 = ovr_cnt;
    ferr_exp = 0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       good;
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      send_frame(d, good);
      if (good) begin
        exp_q.push_back(d);
        tick($urandom_range(0, 30));
      end else begin
        ferr_exp++;
        tick($urandom_range(0, 150));
        uart_rx = 1'b1;
        tick($urandom_range(3, 30));
      end
    end
    uart_rx = 1'b1;
    tick(20);
    check("rand byte count", got_q.size(), exp_q.size());
    while (exp_q.size() != 0) begin
      byte unsigned e;
      e = exp_q.pop_front();
      expect_byte("rand data", e);
    end
    check("rand ferr", ferr_cnt - f0, ferr_exp);
    check("rand ovr", ovr_cnt - o0, 0);

    check("flags exclusive", both_cnt, 0);
    check("data_out stable", stab_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
8N1 UART receiver. Sits directly upstream of the echo/loopback stage. Takes the raw asynchronous uart_rx line, synchronises it, and samples mid-bit with a state machine. Presents each received byte on a one-entry valid/ready holding register and flags framing and overrun errors.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit (12 MHz / 115200); legal range >= 4
HALF_BIT, CLKS_PER_BIT/2, cycles from detected start edge to start-bit mid-sample

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line, idle high
data_out  output  8  received byte, valid while data_valid=1
data_valid  output  1  holding register full
data_ready  input  1  consumer accepts; transfer when data_valid & data_ready
frame_error  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: byte completed while holding register full and not drained

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Synchroniser: two flops on uart_rx. Both reset to 1. All FSM decisions use the second flop (rx_s).
- Bit counter: $clog2(CLKS_PER_BIT) bits wide. Bit index: 3 bits. Shift register: 8 bits, LSB first (shift right, new bit into [7]).
- State IDLE:
  - If rx_s=0, load counter=0 and go to START.
- State START:
  - Count HALF_BIT cycles, then sample rx_s.
  - If rx_s=0: go to DATA, counter=0, index=0.
  - If rx_s=1: treat as a glitch and return to IDLE. No flags.
- State DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register.
  - After index 7 is sampled, go to STOP with counter=0.
- State STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - If rx_s=1: frame accepted and the state returns to IDLE the next cycle.
  - If rx_s=0: frame_error=1 for exactly one cycle, byte discarded, go to WAIT_IDLE.
- State WAIT_IDLE:
  - Stay until rx_s=1, then go to IDLE.
  - This prevents a break or low line from being seen as a new start.
- Holding register, on frame accept:
  - If data_valid=0, or (data_valid & data_ready) in the same cycle: load data_out and set data_valid=1 on the next edge.
  - Otherwise: keep the old data_out and data_valid=1, and pulse overrun for one cycle. The new byte is dropped.
- Holding register, no frame accept:
  - data_valid & data_ready clears data_valid on the next edge.
- data_out is stable while data_valid=1. Its value is don't-care when data_valid=0.
- Latency:
  - Start sample happens 2 (sync) + HALF_BIT cycles after the uart_rx falling edge.
  - data_valid rises one cycle after the stop-bit sample, nominally 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the falling edge.
- Reset values:
  - state=IDLE, sync flops=1.
  - data_out=0, data_valid=0, frame_error=0, overrun=0.
  - Counters and shift register = 0.
- Reset mid-frame aborts the frame. No flags are raised and no partial byte appears.
- frame_error and overrun are never asserted together. They are separate events in separate cycles.
- Back-to-back frames: a start edge immediately after the stop-bit sample (next cycle in IDLE) is detected. No extra idle time is required beyond the stop-bit sample point.

Test Plan:
- CLKS_PER_BIT=104, data_ready=1, send 0x55 with 8N1 at 104 clocks/bit -> data_valid high exactly one cycle, data_out=0x55, ~2+52+936+1 cycles after the falling edge; frame_error=0, overrun=0.
- data_ready=0, send "K" (0x4B) -> data_valid rises and stays 1, data_out=0x4B held. Then raise data_ready for 1 cycle -> data_valid=0 on the next edge.
- data_ready=0, send 0x55 then 0x4B four bit-times apart -> first byte held (data_out=0x55), one-cycle overrun pulse at the second stop sample, data_valid stays 1, data_out still 0x55.
- Drive uart_rx low for 20 cycles then high (glitch shorter than HALF_BIT) -> FSM returns to IDLE, no data_valid, no frame_error. A following 0xA3 is received correctly.
- Send 0xA5 with stop bit=0, hold line low 300 cycles, then high, then send 0x3C -> one frame_error pulse, no data_valid for 0xA5, no spurious frame during the low period, then data_out=0x3C with data_valid.
- Assert reset for 1 cycle during data bit 3 of 0xFF, then send 0x81 -> all outputs 0 after reset, no flags, then data_out=0x81 received clean.
